// File: rtl/cpu_multicycle_if.sv
// Instruction-memory fetch interface for cpu_multicycle.
//   imem_req   : fetch request, held by the core until accepted
//   imem_addr  : fetch address (PCW bits)
//   imem_valid : memory has an instruction for the current request
//   imem_inst  : 32-bit instruction word
// A fetch completes on the rising clock edge where imem_req & imem_valid.
interface cpu_multicycle_if #(
  parameter int PCW = 32
);
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_valid;
  logic [31:0]    imem_inst;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_inst);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_inst);
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU core: FETCH -> EXEC -> WB per instruction, HALT stops it.
// Ports:
//   clk, clrn          : rising-edge clock, asynchronous active-low reset
//   imem (master)      : instruction fetch handshake (see cpu_multicycle_if)
//   pc                 : program counter
//   alu_out            : result of the last flag-updating instruction
//   zf_out/sf_out/cf_out : flag register
//   retire             : one-cycle pulse per completed instruction
//   halted             : high while stopped by HALT
module cpu_multicycle #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int PCW  = 32
) (
  input  logic             clk,
  input  logic             clrn,
  cpu_multicycle_if.master imem,
  output logic [PCW-1:0]   pc,
  output logic [DW-1:0]    alu_out,
  output logic             zf_out,
  output logic             sf_out,
  output logic             cf_out,
  output logic             retire,
  output logic             halted
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t         state_q;
  logic [PCW-1:0] pc_q, npc_q;
  logic [31:0]    ir_q;
  logic [DW-1:0]  alu_q;
  logic           zf_q, sf_q, cf_q;
  logic           req_q, retire_q, halted_q, wreg_q;
  logic [DW-1:0]  regs_q [NREG];

  function automatic logic [DW-1:0] sext16(input logic [15:0] v);
    logic [DW+15:0] t;
    t = {{DW{v[15]}}, v};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] zext16(input logic [15:0] v);
    logic [DW+15:0] t;
    t = {{DW{1'b0}}, v};
    return t[DW-1:0];
  endfunction

  function automatic logic [PCW-1:0] zext8(input logic [7:0] v);
    logic [PCW+7:0] t;
    t = {{PCW{1'b0}}, v};
    return t[PCW-1:0];
  endfunction

  // Instruction fields
  logic [5:0]     op_s;
  logic [RW-1:0]  rc_idx_s, ra_idx_s, rb_idx_s;
  logic [15:0]    imm_s;
  logic [PCW-1:0] jtgt_s, pc_inc_s;
  logic [DW-1:0]  ra_val_s, rb_val_s;
  logic [4:0]     shamt_s;
  logic [DW:0]    add_s, addi_s, shl_s;

  assign op_s     = ir_q[31:26];
  assign rc_idx_s = ir_q[21 +: RW];
  assign ra_idx_s = ir_q[16 +: RW];
  assign rb_idx_s = ir_q[11 +: RW];
  assign imm_s    = ir_q[15:0];
  assign jtgt_s   = zext8(ir_q[25:18]);
  assign pc_inc_s = pc_q + {{(PCW-1){1'b0}}, 1'b1};
  assign ra_val_s = (ra_idx_s == {RW{1'b0}}) ? {DW{1'b0}} : regs_q[ra_idx_s];
  assign rb_val_s = (rb_idx_s == {RW{1'b0}}) ? {DW{1'b0}} : regs_q[rb_idx_s];
  assign shamt_s  = rb_val_s[4:0];
  assign add_s    = {1'b0, ra_val_s} + {1'b0, rb_val_s};
  assign addi_s   = {1'b0, ra_val_s} + {1'b0, sext16(imm_s)};
  // Bit DW of the widened left shift is the last bit shifted out (0 for shift 0)
  assign shl_s    = {1'b0, ra_val_s} << shamt_s;

  logic [DW-1:0]  result_s;
  logic           cf_s, zf_s, sf_s, alu_op_s, halt_s;
  logic [PCW-1:0] npc_s;

  // Execute-stage decode: ALU result, carry, next pc, halt
  always_comb begin
    result_s = {DW{1'b0}};
    cf_s     = 1'b0;
    alu_op_s = 1'b0;
    halt_s   = 1'b0;
    npc_s    = pc_inc_s;
    case (op_s)
      6'h00: begin result_s = add_s[DW-1:0];          cf_s = add_s[DW];            alu_op_s = 1'b1; end
      6'h01: begin result_s = ra_val_s - rb_val_s;    cf_s = (ra_val_s < rb_val_s); alu_op_s = 1'b1; end
      6'h02: begin result_s = ra_val_s & rb_val_s;    alu_op_s = 1'b1; end
      6'h03: begin result_s = ra_val_s | rb_val_s;    alu_op_s = 1'b1; end
      6'h04: begin result_s = ra_val_s ^ rb_val_s;    alu_op_s = 1'b1; end
      6'h05: begin result_s = shl_s[DW-1:0];          cf_s = shl_s[DW];            alu_op_s = 1'b1; end
      6'h06: begin result_s = ra_val_s >> shamt_s;    alu_op_s = 1'b1; end
      6'h08: begin result_s = addi_s[DW-1:0];         cf_s = addi_s[DW];           alu_op_s = 1'b1; end
      6'h09: begin result_s = ra_val_s & zext16(imm_s); alu_op_s = 1'b1; end
      6'h0A: begin result_s = ra_val_s | zext16(imm_s); alu_op_s = 1'b1; end
      6'h10: npc_s = jtgt_s;
      6'h11: if (zf_q) npc_s = jtgt_s; else npc_s = pc_inc_s;
      6'h12: if (sf_q) npc_s = jtgt_s; else npc_s = pc_inc_s;
      6'h13: if (cf_q) npc_s = jtgt_s; else npc_s = pc_inc_s;
      6'h3F: halt_s = 1'b1;
      default: npc_s = pc_inc_s;
    endcase
    zf_s = (result_s == {DW{1'b0}});
    sf_s = result_s[DW-1];
  end

  // Core sequencer: state, pc, IR, flags, register file and all outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_FETCH;
      pc_q     <= {PCW{1'b0}};
      npc_q    <= {PCW{1'b0}};
      ir_q     <= 32'd0;
      alu_q    <= {DW{1'b0}};
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      cf_q     <= 1'b0;
      req_q    <= 1'b0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      wreg_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= {DW{1'b0}};
    end else begin
      case (state_q)
        S_FETCH: begin
          // req_q is low only in the first cycle after reset, so no
          // handshake can complete before the request is visible
          if (req_q && imem.imem_valid) begin
            ir_q    <= imem.imem_inst;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end else begin
            req_q   <= 1'b1;
          end
        end
        S_EXEC: begin
          if (halt_s) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            npc_q    <= npc_s;
            wreg_q   <= alu_op_s;
            retire_q <= 1'b1;
            state_q  <= S_WB;
            if (alu_op_s) begin
              alu_q <= result_s;
              zf_q  <= zf_s;
              sf_q  <= sf_s;
              cf_q  <= cf_s;
            end
          end
        end
        S_WB: begin
          if (wreg_q && (rc_idx_s != {RW{1'b0}})) regs_q[rc_idx_s] <= alu_q;
          pc_q     <= npc_q;
          retire_q <= 1'b0;
          req_q    <= 1'b1;
          state_q  <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc      = pc_q;
  assign alu_out = alu_q;
  assign zf_out  = zf_q;
  assign sf_out  = sf_q;
  assign cf_out  = cf_q;
  assign retire  = retire_q;
  assign halted  = halted_q;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: core 0 is the default build (PCW=32), core 1 a
// PCW=8 build. Each core has an instruction memory with per-address wait
// states and an instruction-level reference model that predicts every
// output cycle by cycle from the handshakes it observes.
module tb_cpu_multicycle;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] clrn;
  logic       force_valid;
  int tests_run = 0;
  int tests_failed = 0;
  localparam int BIG = 32'h7fff_ffff;
  localparam logic [31:0] NOP_W = 32'h8000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rc, input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'd0};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rc, input logic [4:0] ra, input logic [15:0] imm);
    return {op, rc, ra, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [7:0] a);
    return {op, a, 18'd0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_core
    localparam int PW = (g == 0) ? 32 : 8;
    cpu_multicycle_if #(.PCW(PW)) bus ();
    logic [PW-1:0] pc;
    logic [31:0]   alu_out;
    logic          zf, sf, cf, retire, halted;
    logic [31:0]   mem [256];
    int            waits [256];
    int            wcnt;

    cpu_multicycle #(.DW(32), .NREG(32), .PCW(PW)) dut (
      .clk(clk), .clrn(clrn[g]), .imem(bus),
      .pc(pc), .alu_out(alu_out), .zf_out(zf), .sf_out(sf), .cf_out(cf),
      .retire(retire), .halted(halted)
    );

    // memory responder: valid after waits[addr] cycles of request, junk otherwise
    always @(negedge clk) begin
      if (force_valid) begin
        bus.imem_valid = 1'b1;
        bus.imem_inst  = enc_i(6'h08, 5'd1, 5'd0, 16'h0055);
      end else if (!bus.imem_req) begin
        bus.imem_valid = 1'b0;
        bus.imem_inst  = $urandom;
        wcnt = 0;
      end else if (wcnt >= waits[bus.imem_addr[7:0]]) begin
        bus.imem_valid = 1'b1;
        bus.imem_inst  = mem[bus.imem_addr[7:0]];
      end else begin
        bus.imem_valid = 1'b0;
        bus.imem_inst  = $urandom;
        wcnt++;
      end
    end

    // reference model: architectural state plus when each effect shows up
    logic [31:0] m_regs [32];
    logic [63:0] m_pc, vis_pc;
    logic [31:0] m_alu, vis_alu;
    logic        m_z, m_s, m_c, m_halt, vis_z, vis_s, vis_c, vis_halt, prev_clrn;
    int          cyc, t_res, t_pc, retire_t, fetch_at, retire_cnt;

    always @(negedge clk) begin
      logic [31:0] inst, a, b, res;
      logic [15:0] imm;
      logic [63:0] nxt;
      logic        c, upd, hlt, exp_req;
      int          sh;
      #2;
      cyc++;
      if (!clrn[g]) begin
        chk($sformatf("c%0d_rst_pc", g), pc, 0);
        chk($sformatf("c%0d_rst_alu", g), alu_out, 0);
        chk($sformatf("c%0d_rst_flags", g), {zf, sf, cf}, 0);
        chk($sformatf("c%0d_rst_retire", g), retire, 0);
        chk($sformatf("c%0d_rst_halted", g), halted, 0);
        chk($sformatf("c%0d_rst_req", g), bus.imem_req, 0);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 0; vis_pc = 0; m_alu = 0; vis_alu = 0;
        {m_z, m_s, m_c, m_halt, vis_z, vis_s, vis_c, vis_halt} = 8'd0;
        fetch_at = BIG; t_res = BIG; t_pc = BIG; retire_t = BIG;
        retire_cnt = 0; prev_clrn = 1'b0;
      end else begin
        if (!prev_clrn) fetch_at = cyc;
        prev_clrn = 1'b1;
        if (cyc == t_res) begin
          vis_alu = m_alu; vis_z = m_z; vis_s = m_s; vis_c = m_c; vis_halt = m_halt;
        end
        if (cyc == t_pc) vis_pc = m_pc;
        exp_req = !vis_halt && (cyc >= fetch_at);
        chk($sformatf("c%0d_retire@%0d", g, cyc), retire, cyc == retire_t);
        if (retire) retire_cnt++;
        chk($sformatf("c%0d_req@%0d", g, cyc), bus.imem_req, exp_req);
        chk($sformatf("c%0d_pc@%0d", g, cyc), pc, vis_pc);
        chk($sformatf("c%0d_alu@%0d", g, cyc), alu_out, vis_alu);
        chk($sformatf("c%0d_zsc@%0d", g, cyc), {zf, sf, cf}, {vis_z, vis_s, vis_c});
        chk($sformatf("c%0d_halted@%0d", g, cyc), halted, vis_halt);
        if (exp_req) chk($sformatf("c%0d_addr@%0d", g, cyc), bus.imem_addr, vis_pc);
        if (bus.imem_req && bus.imem_valid) begin
          inst = bus.imem_inst;
          a = m_regs[inst[20:16]];
          b = m_regs[inst[15:11]];
          imm = inst[15:0];
          sh = int'(b[4:0]);
          nxt = (m_pc + 64'd1) % (64'd1 << PW);
          upd = 1'b1; hlt = 1'b0; c = 1'b0; res = 32'd0;
          case (inst[31:26])
            6'h00: {c, res} = {1'b0, a} + {1'b0, b};
            6'h01: begin res = a - b; c = (a < b); end
            6'h02: res = a & b;
            6'h03: res = a | b;
            6'h04: res = a ^ b;
            6'h05: begin res = a << sh; c = (sh == 0) ? 1'b0 : a[32 - sh]; end
            6'h06: res = a >> sh;
            6'h08: {c, res} = {1'b0, a} + {1'b0, {{16{imm[15]}}, imm}};
            6'h09: res = a & {16'd0, imm};
            6'h0A: res = a | {16'd0, imm};
            6'h10: begin upd = 1'b0; nxt = {56'd0, inst[25:18]}; end
            6'h11: begin upd = 1'b0; if (m_z) nxt = {56'd0, inst[25:18]}; end
            6'h12: begin upd = 1'b0; if (m_s) nxt = {56'd0, inst[25:18]}; end
            6'h13: begin upd = 1'b0; if (m_c) nxt = {56'd0, inst[25:18]}; end
            6'h3F: begin upd = 1'b0; hlt = 1'b1; end
            default: upd = 1'b0;
          endcase
          if (upd) begin
            m_alu = res; m_z = (res == 32'd0); m_s = res[31]; m_c = c;
            if (inst[25:21] != 5'd0) m_regs[inst[25:21]] = res;
          end
          t_res = cyc + 2;
          fetch_at = cyc + 3;
          if (hlt) m_halt = 1'b1;
          else begin
            m_pc = nxt; t_pc = cyc + 3; retire_t = cyc + 2;
          end
        end
      end
    end
  end

  task automatic step_cyc();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_rc0(input int n);
    int k;
    k = 0;
    while (g_core[0].retire_cnt < n && k < 300) begin step_cyc(); k++; end
    chk($sformatf("c0_reach_retire_%0d", n), g_core[0].retire_cnt >= n, 1);
  endtask

  task automatic wait_halt(input int c);
    int k;
    k = 0;
    while (((c == 0) ? g_core[0].halted : g_core[1].halted) !== 1'b1 && k < 300) begin step_cyc(); k++; end
    chk($sformatf("c%0d_reach_halt", c), (c == 0) ? g_core[0].halted : g_core[1].halted, 1);
  endtask

  initial begin
    int k;
    clrn = 2'b00;
    force_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      g_core[0].mem[i] = NOP_W; g_core[0].waits[i] = 0;
      g_core[1].mem[i] = NOP_W; g_core[1].waits[i] = 0;
    end
    // core 0: arithmetic, flags, jumps, wait states
    g_core[0].mem[0]    = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    g_core[0].mem[1]    = enc_i(6'h08, 5'd2, 5'd0, 16'd7);
    g_core[0].mem[2]    = enc_r(6'h00, 5'd3, 5'd1, 5'd2);
    g_core[0].mem[3]    = enc_r(6'h01, 5'd4, 5'd1, 5'd2);
    g_core[0].mem[4]    = enc_j(6'h11, 8'h20);
    g_core[0].mem[5]    = enc_j(6'h13, 8'h40);
    g_core[0].mem[8'h40] = enc_i(6'h08, 5'd6, 5'd0, 16'hFFFF);
    g_core[0].mem[8'h41] = enc_r(6'h00, 5'd7, 5'd6, 5'd1);
    g_core[0].mem[8'h42] = enc_r(6'h05, 5'd8, 5'd6, 5'd1);
    g_core[0].mem[8'h43] = enc_r(6'h06, 5'd9, 5'd6, 5'd1);
    g_core[0].mem[8'h44] = enc_r(6'h04, 5'd10, 5'd1, 5'd2);
    g_core[0].mem[8'h45] = enc_i(6'h0A, 5'd11, 5'd0, 16'h8000);
    g_core[0].mem[8'h46] = enc_i(6'h09, 5'd12, 5'd6, 16'hF0F0);
    g_core[0].mem[8'h47] = enc_r(6'h02, 5'd13, 5'd9, 5'd11);
    g_core[0].mem[8'h48] = enc_r(6'h03, 5'd14, 5'd13, 5'd10);
    g_core[0].mem[8'h49] = enc_r(6'h05, 5'd15, 5'd1, 5'd0);
    g_core[0].mem[8'h4A] = {6'h3F, 26'd0};
    g_core[0].waits[8'h40] = 4;
    g_core[0].waits[8'h43] = 2;
    // core 1 (PCW=8): pc wrap at 0xFF and r0 write drop
    g_core[1].mem[0]     = enc_j(6'h11, 8'h10);
    g_core[1].mem[1]     = enc_i(6'h08, 5'd1, 5'd0, 16'd3);
    g_core[1].mem[2]     = enc_r(6'h01, 5'd2, 5'd1, 5'd1);
    g_core[1].mem[3]     = enc_j(6'h10, 8'hFF);
    g_core[1].mem[8'h10] = enc_r(6'h00, 5'd0, 5'd1, 5'd1);
    g_core[1].mem[8'h11] = enc_r(6'h00, 5'd5, 5'd0, 5'd0);
    g_core[1].mem[8'h12] = {6'h3F, 26'd0};
    g_core[1].waits[1]   = 1;

    repeat (4) step_cyc();
    #1 force_valid = 1'b0; clrn = 2'b11;

    wait_rc0(3);
    chk("c0_add_alu", g_core[0].alu_out, 32'd12);
    chk("c0_add_zc", {g_core[0].zf, g_core[0].cf}, 2'b00);
    step_cyc();
    chk("c0_pc_after3", g_core[0].pc, 32'd3);
    wait_rc0(4);
    chk("c0_sub_alu", g_core[0].alu_out, 32'hFFFF_FFFE);
    chk("c0_sub_zsc", {g_core[0].zf, g_core[0].sf, g_core[0].cf}, 3'b011);
    wait_rc0(5);
    step_cyc();
    chk("c0_jz_not_taken_pc", g_core[0].pc, 32'd5);
    wait_rc0(6);
    step_cyc();
    chk("c0_jc_taken_pc", g_core[0].pc, 32'h40);
    k = 1;
    while (g_core[0].retire_cnt < 7 && k < 50) begin step_cyc(); k++; end
    chk("c0_wait_retire_clock", k, 7);
    chk("c0_addi_neg_alu", g_core[0].alu_out, 32'hFFFF_FFFF);

    wait_halt(0);
    chk("c0_final_alu", g_core[0].alu_out, 32'd5);
    chk("c0_final_pc", g_core[0].pc, 32'h4A);
    chk("c0_final_retires", g_core[0].retire_cnt, 16);
    wait_halt(1);
    chk("c1_final_pc", g_core[1].pc, 8'h12);
    chk("c1_final_alu", g_core[1].alu_out, 32'd0);
    chk("c1_final_zf", g_core[1].zf, 1);
    chk("c1_final_retires", g_core[1].retire_cnt, 8);

    // HALT at pc=2, then reset recovery and a reset abandoning a fetch
    #1 clrn[0] = 1'b0;
    for (int i = 0; i < 256; i++) begin g_core[0].mem[i] = NOP_W; g_core[0].waits[i] = 0; end
    g_core[0].mem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
    g_core[0].mem[1] = enc_i(6'h08, 5'd2, 5'd0, 16'd2);
    g_core[0].mem[2] = {6'h3F, 26'd0};
    step_cyc();
    step_cyc();
    #1 clrn[0] = 1'b1;
    wait_halt(0);
    repeat (25) step_cyc();
    chk("c0_halt_held", g_core[0].halted, 1);
    chk("c0_halt_req", g_core[0].bus.imem_req, 0);
    chk("c0_halt_pc", g_core[0].pc, 32'd2);
    chk("c0_halt_retires", g_core[0].retire_cnt, 2);
    #1 clrn[0] = 1'b0;
    step_cyc();
    chk("c0_unhalt_halted", g_core[0].halted, 0);
    chk("c0_unhalt_pc", g_core[0].pc, 32'd0);
    g_core[0].waits[0] = 3;
    #1 clrn[0] = 1'b1;
    step_cyc();
    chk("c0_midfetch_req", g_core[0].bus.imem_req, 1);
    #1 clrn[0] = 1'b0; force_valid = 1'b1;
    repeat (3) step_cyc();
    chk("c0_midfetch_no_retire", g_core[0].retire_cnt, 0);
    #1 force_valid = 1'b0; clrn[0] = 1'b1;
    wait_halt(0);
    chk("c0_rerun_pc", g_core[0].pc, 32'd2);
    chk("c0_rerun_alu", g_core[0].alu_out, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle core. The core fetches 32-bit instructions over a valid/ready-style instruction-memory handshake that tolerates wait states. A four-state FSM sequences fetch, execute and writeback, and a HALT opcode stops the core. Data width, register count and PC width are generic; the instruction encoding stays 32-bit.

Parameters:
DW, 32, datapath and register width (>=8)
NREG, 32, register count (power of 2, <=32); register index = low log2(NREG) bits of field
PCW, 32, PC / instruction-address width (>=8)

Ports:
clk  input  1  clock, rising edge
clrn  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, held until accepted
imem_addr  output  PCW  fetch address (= pc while imem_req)
imem_valid  input  1  imem_inst valid; fetch completes on imem_req & imem_valid
imem_inst  input  32  instruction word
pc  output  PCW  program counter
alu_out  output  DW  registered ALU result of last executed instruction
zf_out, sf_out, cf_out  output  1 each  flag register
retire  output  1  one-cycle pulse per completed instruction
halted  output  1  high while in HALT

Behaviour:
- Reset (clk/clrn): asynchronous, active-low. While clrn=0: pc=0, alu_out=0, flags=0, retire=0, halted=0, imem_req=0, all registers=0, state=FETCH. Reset mid-fetch abandons the request with no handshake completion. imem_req rises the first clock edge after clrn goes high.
- Fields: op=inst[31:26], rc=[25:21] (dest), ra=[20:16], rb=[15:11], imm=[15:0], addr=[25:18].
- Register file: register 0 reads 0, writes to it are dropped. Each read is combinational from the register array.
- FSM:
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid, latch IR and go to EXEC. Otherwise stay (unlimited wait states). imem_inst is ignored without imem_valid.
  - EXEC: read ra/rb, compute result, latch alu_out and flags for ALU ops, compute next pc. Go to WB, or to HALT for HALT.
  - WB: write rc if wreg, load pc, retire=1, go to FETCH.
  - HALT: halted=1, pc frozen, imem_req=0. Leave only by reset.
- Minimum latency: 3 clocks per instruction (FETCH with same-cycle valid, EXEC, WB). Each memory wait state adds 1 clock.
- Opcodes (hex):
  - ALU, write rc, update flags: 00 ADD ra+rb; 01 SUB ra-rb; 02 AND; 03 OR; 04 XOR; 05 SHL ra<<rb[4:0]; 06 SHR logical ra>>rb[4:0].
  - Immediate forms, write rc, update flags: 08 ADDI ra+sext(imm); 09 ANDI ra&zext(imm); 0A ORI ra|zext(imm). imm is sign-/zero-extended or truncated to DW.
  - Jumps, no write, flags unchanged: 10 JMP; 11 JZ if zf; 12 JS if sf; 13 JC if cf. Target = zext(addr) to PCW.
  - 3F HALT.
  - Any other opcode: NOP (pc+1, retire pulses, no write, flags unchanged).
- Flags from DW-bit result:
  - zf = result==0; sf = result[DW-1].
  - cf: ADD/ADDI carry out of bit DW-1; SUB borrow (1 iff ra<rb unsigned); SHL last bit shifted out (0 if shift=0); SHR 0; logic ops 0.
- Flag source: a conditional jump tests the flag register, i.e. the flags of the most recent flag-updating instruction.
- PC arithmetic: pc+1 modulo 2^PCW; all-ones wraps to 0. Not-taken jumps go to pc+1.
- alu_out holds its value through jumps and NOPs.

Test Plan:
1. Reset: hold clrn=0 across edges mid-FETCH with imem_valid=1 -> pc=0, imem_req=0, no retire, all outputs 0; first retire is 3 clocks after the first request.
2. ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 -> alu_out=12, zf=0, cf=0, 3 retires 3 clocks apart, pc=3.
3. SUB r4,r1,r2 (5-7) then JC 0x40 -> alu_out=0xFFFFFFFE, sf=1, cf=1, jump taken, pc=0x40. The same pattern with JZ is not taken, pc=pc+1.
4. Wait states: imem_valid withheld 4 clocks -> imem_req and imem_addr held stable, instruction retires at clock 7 of the request, no early register write.
5. HALT at pc=2 -> halted=1 after EXEC, no retire, imem_req=0 for 20+ clocks. Then pulse clrn -> halted=0, pc=0.
6. PCW=8 build: NOP at pc=0xFF -> pc=0x00. ADD r0,r1,r1 leaves r0 reading 0.
